controle_multiciclo: RTL
========================

# controle_multiciclo

Parametrised multicycle control unit for the processor datapath. Accepts one opcode per instruction through a valid/busy handshake and sequences it through a fetch/decode/execute/write-back/PC-update state machine. Drives the datapath strobes (EscIR, EscReg, EscCP, EscCondCP) and the ALU and PC-source selects. Supports configurable opcode width, ALU-op width, execute latency and opcode-class maps, plus an illegal-opcode flag.

## Interface
Parameters:
- OPCODE_W, 4, opcode width
- ULA_OP_W, 4, ALU operation width; ULA_OP_W <= OPCODE_W, ULA_OP = low ULA_OP_W bits of latched opcode
- EXEC_CYCLES, 4, execute-phase length in cycles for R/I classes; legal range >= 1
- R_MASK, 16'h003B, bit n set => opcode n is register-register class (default opcodes 0,1,3,4,5)
- I_MASK, 16'h07C4, bit n set => opcode n is immediate class (default opcodes 2,6,7,8,9,10)
- OP_JUMP, 11, jump opcode
- OP_BRANCH, 12, conditional-branch opcode

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  OPCODE_W  instruction opcode, sampled only on acceptance
- instr_valid  in  1  opcode available; accepted only in IDLE
- ocupado  out  1  high in every state except IDLE
- fim  out  1  one-cycle pulse in the last cycle of a legal instruction
- erro  out  1  one-cycle pulse when the decoded opcode is illegal
- EscIR  out  1  instruction-register write
- EscReg  out  1  register-file write
- EscCP  out  1  unconditional PC write
- EscCondCP  out  1  conditional PC write
- ULA_A  out  1  ALU A select (1 = register, 0 = PC)
- ULA_B  out  2  ALU B select (00 = register, 10 = immediate)
- ULA_OP  out  ULA_OP_W  ALU operation
- FonteCP  out  2  PC source (00 = ALU, 01 = branch target, 10 = jump target)

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, PCUPD, JUMP, BRANCH. All outputs are Moore functions of state and latched opcode op_q. Any output not listed for a state is 0.
- IDLE: ocupado=0. If instr_valid=1, latch op_q<=opcode and go to FETCH. Otherwise stay in IDLE.
- FETCH: EscIR=1. Go to DECODE.
- DECODE: classify op_q. Bit op_q of R_MASK set => R. Bit op_q of I_MASK set => I. op_q==OP_JUMP => JUMP. op_q==OP_BRANCH => BRANCH. Otherwise erro=1 and go to IDLE. Priority for overlapping maps: R > I > JUMP > BRANCH. Opcodes >= 16 are illegal unless equal to OP_JUMP or OP_BRANCH.
- R/I: load counter with EXEC_CYCLES-1 and go to EXEC.
- EXEC: ULA_A=1, ULA_B=00 (R) or 10 (I), ULA_OP=op_q[ULA_OP_W-1:0]. Decrement the counter each cycle. When the counter reaches 0, go to WB. Counter width is $clog2(EXEC_CYCLES+1).
- WB: same ALU selects as EXEC, plus EscReg=1. Go to PCUPD.
- PCUPD: EscCP=1, FonteCP=00, fim=1. Go to IDLE.
- JUMP: ULA_A=0, ULA_B=10, FonteCP=10, EscCP=1, fim=1. Go to IDLE.
- BRANCH: ULA_A=0, ULA_B=00, FonteCP=01, EscCondCP=1, EscCP=0, fim=1. Go to IDLE.
- ULA_OP=0 outside EXEC/WB.
- Changes on opcode and instr_valid while ocupado=1 are ignored. op_q is stable for the whole instruction.

## Timing
- Reset: state=IDLE, op_q=0, counter=0. All outputs 0 from the cycle after the reset edge. Reset during any state aborts the instruction; no strobe is asserted after the reset edge.
- Acceptance edge is T0. FETCH is at T0+1 and DECODE at T0+2.
- R/I: EXEC spans T0+3 .. T0+2+EXEC_CYCLES. WB is at T0+3+EXEC_CYCLES. PCUPD/fim is at T0+4+EXEC_CYCLES. IDLE follows at T0+5+EXEC_CYCLES.
- Jump/branch: strobe cycle at T0+3, IDLE at T0+4.
- Illegal opcode: erro at T0+2, IDLE at T0+3. fim is not asserted.
- Back-to-back: instr_valid held high in the first IDLE cycle is accepted on that edge. Minimum gap between instructions is therefore one IDLE cycle.
- EscReg, EscCP, EscCondCP, EscIR, fim and erro are each exactly one cycle wide per instruction. No two of EscReg/EscCP/EscCondCP are ever high together.

## Test plan
- Default params, opcode=3 (R) with instr_valid pulse -> EscIR at T0+1; ULA_A=1, ULA_B=00, ULA_OP=3 at T0+3..T0+6; EscReg at T0+7; EscCP+fim at T0+8 with FonteCP=00; ocupado falls at T0+9.
- opcode=7 (I), EXEC_CYCLES=1 -> ULA_B=10 in EXEC at T0+3; EscReg at T0+4; EscCP/fim at T0+5.
- opcode=11 -> at T0+3: EscCP=1, FonteCP=10, ULA_A=0, ULA_B=10, fim=1. opcode=12 -> at T0+3: EscCondCP=1, EscCP=0, FonteCP=01.
- opcode=14 (illegal) -> erro pulse at T0+2; no EscReg/EscCP/EscCondCP; IDLE at T0+3.
- Toggle opcode and instr_valid every cycle during an R instruction -> strobe sequence and ULA_OP identical to the undisturbed case.
- Assert reset during EXEC -> next cycle all outputs 0, ocupado=0. A new instruction accepted afterwards completes normally.

Source files
------------

// File: rtl/controle_multiciclo_if.sv
// Handshake and datapath-control bundle between the sequencer and its instruction source / datapath.
// master drives opcode/instr_valid; slave (the control unit) drives status and datapath strobes.
interface controle_multiciclo_if #(
  parameter int OPCODE_W = 4,
  parameter int ULA_OP_W = 4
);
  logic [OPCODE_W-1:0] opcode;
  logic                instr_valid;
  logic                ocupado;
  logic                fim;
  logic                erro;
  logic                EscIR;
  logic                EscReg;
  logic                EscCP;
  logic                EscCondCP;
  logic                ULA_A;
  logic [1:0]          ULA_B;
  logic [ULA_OP_W-1:0] ULA_OP;
  logic [1:0]          FonteCP;

  modport master (
    output opcode, instr_valid,
    input  ocupado, fim, erro, EscIR, EscReg, EscCP, EscCondCP,
    input  ULA_A, ULA_B, ULA_OP, FonteCP
  );

  modport slave (
    input  opcode, instr_valid,
    output ocupado, fim, erro, EscIR, EscReg, EscCP, EscCondCP,
    output ULA_A, ULA_B, ULA_OP, FonteCP
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM: fetch/decode/execute/write-back/PC-update sequencing with Moore outputs.
// Latency: R/I = EXEC_CYCLES+4 busy cycles, jump/branch = 3, illegal = 2; new opcodes accepted only in IDLE.
module controle_multiciclo #(
  parameter int          OPCODE_W    = 4,
  parameter int          ULA_OP_W    = 4,
  parameter int          EXEC_CYCLES = 4,
  parameter logic [15:0] R_MASK      = 16'h003B,
  parameter logic [15:0] I_MASK      = 16'h07C4,
  parameter int          OP_JUMP     = 11,
  parameter int          OP_BRANCH   = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  controle_multiciclo_if.slave  bus
);

  localparam int CNT_W = $clog2(EXEC_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] PCUPD  = 3'd5;
  localparam logic [2:0] JUMP   = 3'd6;
  localparam logic [2:0] BRANCH = 3'd7;

  logic [2:0]          state;
  logic [OPCODE_W-1:0] op_q;
  logic [CNT_W-1:0]    cnt;

  logic [31:0] op_idx;
  logic        is_r, is_i, is_j, is_b;

  // Opcodes beyond the 16-entry class maps can only be jump or branch.
  always_comb begin
    op_idx = 32'(op_q);
    is_r   = (op_idx < 32'd16) && R_MASK[op_idx[3:0]];
    is_i   = (op_idx < 32'd16) && I_MASK[op_idx[3:0]];
    is_j   = (op_idx == 32'(OP_JUMP));
    is_b   = (op_idx == 32'(OP_BRANCH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            op_q  <= bus.opcode;
            state <= FETCH;
          end
        end
        FETCH:  state <= DECODE;
        DECODE: begin
          if (is_r || is_i) begin
            cnt   <= CNT_LOAD;
            state <= EXEC;
          end else if (is_j) begin
            state <= JUMP;
          end else if (is_b) begin
            state <= BRANCH;
          end else begin
            state <= IDLE;
          end
        end
        EXEC: begin
          if (cnt == '0) state <= WB;
          else           cnt   <= cnt - CNT_W'(1);
        end
        WB:      state <= PCUPD;
        default: state <= IDLE;
      endcase
    end
  end

  logic                ocupado_c, fim_c, erro_c;
  logic                esc_ir_c, esc_reg_c, esc_cp_c, esc_cond_cp_c;
  logic                ula_a_c;
  logic [1:0]          ula_b_c, fonte_cp_c;
  logic [ULA_OP_W-1:0] ula_op_c;

  // EXEC is only reachable from R or I, and R wins on overlap, so is_r alone picks ULA_B.
  always_comb begin
    ocupado_c     = (state != IDLE);
    fim_c         = 1'b0;
    erro_c        = 1'b0;
    esc_ir_c      = 1'b0;
    esc_reg_c     = 1'b0;
    esc_cp_c      = 1'b0;
    esc_cond_cp_c = 1'b0;
    ula_a_c       = 1'b0;
    ula_b_c       = 2'b00;
    ula_op_c      = '0;
    fonte_cp_c    = 2'b00;
    case (state)
      FETCH:  esc_ir_c = 1'b1;
      DECODE: erro_c   = !(is_r || is_i || is_j || is_b);
      EXEC, WB: begin
        ula_a_c   = 1'b1;
        ula_b_c   = is_r ? 2'b00 : 2'b10;
        ula_op_c  = op_q[ULA_OP_W-1:0];
        esc_reg_c = (state == WB);
      end
      PCUPD: begin
        esc_cp_c = 1'b1;
        fim_c    = 1'b1;
      end
      JUMP: begin
        ula_b_c    = 2'b10;
        fonte_cp_c = 2'b10;
        esc_cp_c   = 1'b1;
        fim_c      = 1'b1;
      end
      BRANCH: begin
        fonte_cp_c    = 2'b01;
        esc_cond_cp_c = 1'b1;
        fim_c         = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ocupado   = ocupado_c;
  assign bus.fim       = fim_c;
  assign bus.erro      = erro_c;
  assign bus.EscIR     = esc_ir_c;
  assign bus.EscReg    = esc_reg_c;
  assign bus.EscCP     = esc_cp_c;
  assign bus.EscCondCP = esc_cond_cp_c;
  assign bus.ULA_A     = ula_a_c;
  assign bus.ULA_B     = ula_b_c;
  assign bus.ULA_OP    = ula_op_c;
  assign bus.FonteCP   = fonte_cp_c;

endmodule
